// File: rtl/lotr_pkg.sv
// rtl/lotr_pkg.sv - LOTR ring slot types, address field positions and shared helpers.
package lotr_pkg;

    typedef enum logic [1:0] {
        RD     = 2'd0,
        WR     = 2'd1,
        RD_RSP = 2'd2,
        WR_ACK = 2'd3
    } t_ring_opcode;

    typedef struct packed {
        logic         valid;
        t_ring_opcode opcode;
        logic [31:0]  address;
        logic [31:0]  data;
    } t_ring_slot;

    localparam int DEST_MSB = 31;
    localparam int DEST_LSB = 24;
    localparam int SRC_MSB  = 23;
    localparam int SRC_LSB  = 16;

    function automatic logic [31:0] sat_add32(input logic [31:0] cnt, input logic [1:0] inc);
        logic [32:0] w_sum;
        w_sum = {1'b0, cnt} + {31'b0, inc};
        return w_sum[32] ? 32'hFFFF_FFFF : w_sum[31:0];
    endfunction

endpackage

// File: rtl/lotr_rs_fifo.sv
// rtl/lotr_rs_fifo.sv - synchronous ring-slot FIFO with wrap-bit pointers and a registered not-full flag.
module lotr_rs_fifo
    import lotr_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_push,
    input  t_ring_slot i_wr_slot,
    input  logic       i_pop,
    output t_ring_slot o_rd_slot,
    output logic       o_empty,
    output logic       o_not_full_q
);

    localparam int AW = $clog2(DEPTH);

    t_ring_slot      r_mem [DEPTH];
    logic [AW:0]     r_wptr;
    logic [AW:0]     r_rptr;
    logic [AW:0]     w_wptr_nxt;
    logic [AW:0]     w_rptr_nxt;
    logic            w_push;
    logic            w_pop;
    logic            w_full_nxt;

    // r_not_full_q is loaded from the next pointers, so it always equals !full of the current pointers.
    assign o_empty    = (r_wptr == r_rptr);
    assign w_push     = i_push && o_not_full_q;
    assign w_pop      = i_pop && !o_empty;
    assign w_wptr_nxt = r_wptr + {{AW{1'b0}}, w_push};
    assign w_rptr_nxt = r_rptr + {{AW{1'b0}}, w_pop};
    assign w_full_nxt = (w_wptr_nxt[AW] != w_rptr_nxt[AW]) &&
                        (w_wptr_nxt[AW-1:0] == w_rptr_nxt[AW-1:0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr       <= '0;
            r_rptr       <= '0;
            o_not_full_q <= 1'b1;
        end else begin
            r_wptr       <= w_wptr_nxt;
            r_rptr       <= w_rptr_nxt;
            o_not_full_q <= !w_full_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr[AW-1:0]] <= i_wr_slot;
        end
    end

    assign o_rd_slot = o_empty ? '0 : r_mem[r_rptr[AW-1:0]];

endmodule

// File: rtl/lotr_ring_stop.sv
// rtl/lotr_ring_stop.sv - LOTR tile ring stop: Q501/Q502 slot pipeline, eject to F2C, inject from C2F.
// Optional perf counters enabled by defining LOTR_RS_PERF_CNT_EN.
module lotr_ring_stop
    import lotr_pkg::*;
#(
    parameter int RS_FIFO_DEPTH = 4
) (
    input  logic        QClk,
    input  logic        RstQnnnL,
    input  logic [7:0]  tile_id,
    input  logic        RingInputValidQ500H,
    input  logic [1:0]  RingInputOpcodeQ500H,
    input  logic [31:0] RingInputAddressQ500H,
    input  logic [31:0] RingInputDataQ500H,
    output logic        RingOutputValidQ502H,
    output logic [1:0]  RingOutputOpcodeQ502H,
    output logic [31:0] RingOutputAddressQ502H,
    output logic [31:0] RingOutputDataQ502H,
    input  logic        C2F_ReqValidQ500H,
    output logic        C2F_ReqReadyQ500H,
    input  logic [1:0]  C2F_ReqOpcodeQ500H,
    input  logic [31:0] C2F_ReqAddressQ500H,
    input  logic [31:0] C2F_ReqDataQ500H,
    output logic        F2C_ReqValidQ502H,
    input  logic        F2C_ReqReadyQ502H,
    output logic [1:0]  F2C_ReqOpcodeQ502H,
    output logic [31:0] F2C_ReqAddressQ502H,
    output logic [31:0] F2C_ReqDataQ502H
`ifdef LOTR_RS_PERF_CNT_EN
    ,
    output logic [31:0] RsInjectCntQ502H,
    output logic [31:0] RsEjectCntQ502H,
    output logic [31:0] RsBlockCntQ502H
`endif
);

    t_ring_slot w_in_slot;
    t_ring_slot w_c2f_wr_slot;
    t_ring_slot w_c2f_head;
    t_ring_slot w_f2c_head;
    t_ring_slot w_slot_nxt;
    t_ring_slot r_slot_q501;
    t_ring_slot r_slot_q502;

    logic w_c2f_empty;
    logic w_c2f_not_full;
    logic w_f2c_empty;
    logic w_f2c_not_full;
    logic w_c2f_push;
    logic w_f2c_pop;
    logic w_dest_match;
    logic w_eject;
    logic w_free;
    logic w_inject;

    assign w_in_slot = '{valid:   RingInputValidQ500H,
                         opcode:  t_ring_opcode'(RingInputOpcodeQ500H),
                         address: RingInputAddressQ500H,
                         data:    RingInputDataQ500H};

    assign w_c2f_wr_slot = '{valid:   1'b1,
                             opcode:  t_ring_opcode'(C2F_ReqOpcodeQ500H),
                             address: C2F_ReqAddressQ500H,
                             data:    C2F_ReqDataQ500H};

    assign C2F_ReqReadyQ500H = w_c2f_not_full;
    assign w_c2f_push        = C2F_ReqValidQ500H && C2F_ReqReadyQ500H;
    assign F2C_ReqValidQ502H = !w_f2c_empty;
    assign w_f2c_pop         = F2C_ReqValidQ502H && F2C_ReqReadyQ502H;

    // A slot for this tile that finds the F2C FIFO full stays on the ring and retries next lap.
    assign w_dest_match = r_slot_q501.valid && (r_slot_q501.address[DEST_MSB:DEST_LSB] == tile_id);
    assign w_eject      = w_dest_match && w_f2c_not_full;
    assign w_free       = !r_slot_q501.valid || w_eject;
    assign w_inject     = w_free && !w_c2f_empty;

    always_comb begin
        w_slot_nxt = r_slot_q501;
        if (w_inject) begin
            w_slot_nxt                            = w_c2f_head;
            w_slot_nxt.valid                      = 1'b1;
            w_slot_nxt.address[SRC_MSB:SRC_LSB]   = tile_id;
        end else if (w_eject) begin
            w_slot_nxt = '0;
        end
    end

    always_ff @(posedge QClk or negedge RstQnnnL) begin
        if (!RstQnnnL) begin
            r_slot_q501 <= '0;
            r_slot_q502 <= '0;
        end else begin
            r_slot_q501 <= w_in_slot;
            r_slot_q502 <= w_slot_nxt;
        end
    end

    lotr_rs_fifo #(.DEPTH(RS_FIFO_DEPTH)) u_c2f_fifo (
        .clk          (QClk),
        .rst_n        (RstQnnnL),
        .i_push       (w_c2f_push),
        .i_wr_slot    (w_c2f_wr_slot),
        .i_pop        (w_inject),
        .o_rd_slot    (w_c2f_head),
        .o_empty      (w_c2f_empty),
        .o_not_full_q (w_c2f_not_full)
    );

    lotr_rs_fifo #(.DEPTH(RS_FIFO_DEPTH)) u_f2c_fifo (
        .clk          (QClk),
        .rst_n        (RstQnnnL),
        .i_push       (w_eject),
        .i_wr_slot    (r_slot_q501),
        .i_pop        (w_f2c_pop),
        .o_rd_slot    (w_f2c_head),
        .o_empty      (w_f2c_empty),
        .o_not_full_q (w_f2c_not_full)
    );

    assign RingOutputValidQ502H   = r_slot_q502.valid;
    assign RingOutputOpcodeQ502H  = r_slot_q502.opcode;
    assign RingOutputAddressQ502H = r_slot_q502.address;
    assign RingOutputDataQ502H    = r_slot_q502.data;

    assign F2C_ReqOpcodeQ502H  = w_f2c_head.opcode;
    assign F2C_ReqAddressQ502H = w_f2c_head.address;
    assign F2C_ReqDataQ502H    = w_f2c_head.data;

`ifdef LOTR_RS_PERF_CNT_EN
    logic [1:0] w_block_inc;

    // A stalled injection and a refused eject in the same cycle both count.
    assign w_block_inc = {1'b0, (!w_c2f_empty && !w_free)} + {1'b0, (w_dest_match && !w_f2c_not_full)};

    always_ff @(posedge QClk or negedge RstQnnnL) begin
        if (!RstQnnnL) begin
            RsInjectCntQ502H <= '0;
            RsEjectCntQ502H  <= '0;
            RsBlockCntQ502H  <= '0;
        end else begin
            RsInjectCntQ502H <= sat_add32(RsInjectCntQ502H, {1'b0, w_inject});
            RsEjectCntQ502H  <= sat_add32(RsEjectCntQ502H, {1'b0, w_eject});
            RsBlockCntQ502H  <= sat_add32(RsBlockCntQ502H, w_block_inc);
        end
    end
`endif

endmodule

// File: tb/tb_lotr_ring_stop.sv
// tb/tb_lotr_ring_stop.sv - directed self-checking bench for lotr_ring_stop.
module tb_lotr_ring_stop;

    logic        QClk;
    logic        RstQnnnL;
    logic [7:0]  tile_id;
    logic        RingInputValidQ500H;
    logic [1:0]  RingInputOpcodeQ500H;
    logic [31:0] RingInputAddressQ500H;
    logic [31:0] RingInputDataQ500H;
    logic        RingOutputValidQ502H;
    logic [1:0]  RingOutputOpcodeQ502H;
    logic [31:0] RingOutputAddressQ502H;
    logic [31:0] RingOutputDataQ502H;
    logic        C2F_ReqValidQ500H;
    logic        C2F_ReqReadyQ500H;
    logic [1:0]  C2F_ReqOpcodeQ500H;
    logic [31:0] C2F_ReqAddressQ500H;
    logic [31:0] C2F_ReqDataQ500H;
    logic        F2C_ReqValidQ502H;
    logic        F2C_ReqReadyQ502H;
    logic [1:0]  F2C_ReqOpcodeQ502H;
    logic [31:0] F2C_ReqAddressQ502H;
    logic [31:0] F2C_ReqDataQ502H;

    int checks = 0;
    int errors = 0;

    lotr_ring_stop #(.RS_FIFO_DEPTH(4)) dut (
        .QClk                   (QClk),
        .RstQnnnL               (RstQnnnL),
        .tile_id                (tile_id),
        .RingInputValidQ500H    (RingInputValidQ500H),
        .RingInputOpcodeQ500H   (RingInputOpcodeQ500H),
        .RingInputAddressQ500H  (RingInputAddressQ500H),
        .RingInputDataQ500H     (RingInputDataQ500H),
        .RingOutputValidQ502H   (RingOutputValidQ502H),
        .RingOutputOpcodeQ502H  (RingOutputOpcodeQ502H),
        .RingOutputAddressQ502H (RingOutputAddressQ502H),
        .RingOutputDataQ502H    (RingOutputDataQ502H),
        .C2F_ReqValidQ500H      (C2F_ReqValidQ500H),
        .C2F_ReqReadyQ500H      (C2F_ReqReadyQ500H),
        .C2F_ReqOpcodeQ500H     (C2F_ReqOpcodeQ500H),
        .C2F_ReqAddressQ500H    (C2F_ReqAddressQ500H),
        .C2F_ReqDataQ500H       (C2F_ReqDataQ500H),
        .F2C_ReqValidQ502H      (F2C_ReqValidQ502H),
        .F2C_ReqReadyQ502H      (F2C_ReqReadyQ502H),
        .F2C_ReqOpcodeQ502H     (F2C_ReqOpcodeQ502H),
        .F2C_ReqAddressQ502H    (F2C_ReqAddressQ502H),
        .F2C_ReqDataQ502H       (F2C_ReqDataQ502H)
    );

    initial QClk = 1'b0;
    always #5 QClk = ~QClk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge QClk);
        #1;
    endtask

    task automatic ring_in(input logic v, input logic [1:0] op, input logic [31:0] a, input logic [31:0] d);
        RingInputValidQ500H   = v;
        RingInputOpcodeQ500H  = op;
        RingInputAddressQ500H = a;
        RingInputDataQ500H    = d;
    endtask

    task automatic c2f_in(input logic v, input logic [1:0] op, input logic [31:0] a, input logic [31:0] d);
        C2F_ReqValidQ500H   = v;
        C2F_ReqOpcodeQ500H  = op;
        C2F_ReqAddressQ500H = a;
        C2F_ReqDataQ500H    = d;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ring_valid"}, {31'b0, RingOutputValidQ502H}, 32'd0);
        chk({tag, "_ring_op"},    {30'b0, RingOutputOpcodeQ502H}, 32'd0);
        chk({tag, "_ring_addr"},  RingOutputAddressQ502H, 32'd0);
        chk({tag, "_ring_data"},  RingOutputDataQ502H, 32'd0);
        chk({tag, "_f2c_valid"},  {31'b0, F2C_ReqValidQ502H}, 32'd0);
        chk({tag, "_f2c_addr"},   F2C_ReqAddressQ502H, 32'd0);
        chk({tag, "_f2c_data"},   F2C_ReqDataQ502H, 32'd0);
        chk({tag, "_c2f_ready"},  {31'b0, C2F_ReqReadyQ500H}, 32'd1);
    endtask

    initial begin
        tile_id           = 8'h03;
        RstQnnnL          = 1'b0;
        F2C_ReqReadyQ502H = 1'b0;
        ring_in(1'b0, 2'd0, 32'h0, 32'h0);
        c2f_in(1'b0, 2'd0, 32'h0, 32'h0);
        step();
        step();
        chk_reset_outputs("reset");
        RstQnnnL = 1'b1;
        step();

        // Pass-through of a slot for another tile.
        ring_in(1'b1, 2'd0, 32'h0501_0020, 32'hCAFE_0001);
        step();
        ring_in(1'b0, 2'd0, 32'h0, 32'h0);
        step();
        chk("pass_valid", {31'b0, RingOutputValidQ502H}, 32'd1);
        chk("pass_addr",  RingOutputAddressQ502H, 32'h0501_0020);
        chk("pass_data",  RingOutputDataQ502H, 32'hCAFE_0001);
        chk("pass_op",    {30'b0, RingOutputOpcodeQ502H}, 32'd0);
        chk("pass_f2c",   {31'b0, F2C_ReqValidQ502H}, 32'd0);

        // Eject of a slot addressed to this tile.
        ring_in(1'b1, 2'd1, 32'h0301_0004, 32'h1234_5678);
        step();
        ring_in(1'b0, 2'd0, 32'h0, 32'h0);
        step();
        chk("ej_ring_valid", {31'b0, RingOutputValidQ502H}, 32'd0);
        chk("ej_f2c_valid",  {31'b0, F2C_ReqValidQ502H}, 32'd1);
        chk("ej_f2c_data",   F2C_ReqDataQ502H, 32'h1234_5678);
        chk("ej_f2c_addr",   F2C_ReqAddressQ502H, 32'h0301_0004);
        chk("ej_f2c_op",     {30'b0, F2C_ReqOpcodeQ502H}, 32'd1);
        F2C_ReqReadyQ502H = 1'b1;
        step();
        F2C_ReqReadyQ502H = 1'b0;
        chk("ej_pop_empty", {31'b0, F2C_ReqValidQ502H}, 32'd0);

        // Injection overwrites the source tile field.
        c2f_in(1'b1, 2'd1, 32'h0700_0010, 32'hA5A5_A5A5);
        step();
        c2f_in(1'b0, 2'd0, 32'h0, 32'h0);
        step();
        chk("inj_valid", {31'b0, RingOutputValidQ502H}, 32'd1);
        chk("inj_addr",  RingOutputAddressQ502H, 32'h0703_0010);
        chk("inj_data",  RingOutputDataQ502H, 32'hA5A5_A5A5);
        chk("inj_op",    {30'b0, RingOutputOpcodeQ502H}, 32'd1);
        step();
        chk("inj_once", {31'b0, RingOutputValidQ502H}, 32'd0);

        // F2C full: four ejects, fifth slot passes through.
        for (int i = 0; i < 5; i++) begin
            ring_in(1'b1, 2'd0, 32'h0302_0000 + i, 32'h0000_0100 + i);
            step();
            if (i >= 1) chk($sformatf("full_ej%0d_ring_valid", i - 1), {31'b0, RingOutputValidQ502H}, 32'd0);
        end
        ring_in(1'b0, 2'd0, 32'h0, 32'h0);
        step();
        chk("full_pass_valid", {31'b0, RingOutputValidQ502H}, 32'd1);
        chk("full_pass_data",  RingOutputDataQ502H, 32'h0000_0104);
        chk("full_pass_addr",  RingOutputAddressQ502H, 32'h0302_0004);
        F2C_ReqReadyQ502H = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("full_pop%0d_valid", k), {31'b0, F2C_ReqValidQ502H}, 32'd1);
            chk($sformatf("full_pop%0d_data", k),  F2C_ReqDataQ502H, 32'h0000_0100 + k);
            step();
        end
        F2C_ReqReadyQ502H = 1'b0;
        chk("full_drained", {31'b0, F2C_ReqValidQ502H}, 32'd0);

        // Simultaneous eject and inject.
        ring_in(1'b1, 2'd3, 32'h0302_0008, 32'h5A5A_0003);
        c2f_in(1'b1, 2'd2, 32'h0900_0044, 32'hBEEF_0005);
        step();
        ring_in(1'b0, 2'd0, 32'h0, 32'h0);
        c2f_in(1'b0, 2'd0, 32'h0, 32'h0);
        step();
        chk("both_ring_valid", {31'b0, RingOutputValidQ502H}, 32'd1);
        chk("both_ring_addr",  RingOutputAddressQ502H, 32'h0903_0044);
        chk("both_ring_data",  RingOutputDataQ502H, 32'hBEEF_0005);
        chk("both_ring_op",    {30'b0, RingOutputOpcodeQ502H}, 32'd2);
        chk("both_f2c_valid",  {31'b0, F2C_ReqValidQ502H}, 32'd1);
        chk("both_f2c_data",   F2C_ReqDataQ502H, 32'h5A5A_0003);
        chk("both_f2c_op",     {30'b0, F2C_ReqOpcodeQ502H}, 32'd3);
        F2C_ReqReadyQ502H = 1'b1;
        step();
        F2C_ReqReadyQ502H = 1'b0;

        // Half-fill both FIFOs with a busy ring, then reset mid-cycle.
        ring_in(1'b1, 2'd1, 32'h0301_0000, 32'h0000_00D0);
        step();
        ring_in(1'b1, 2'd1, 32'h0301_0001, 32'h0000_00D1);
        step();
        ring_in(1'b1, 2'd0, 32'h0501_0000, 32'h0000_0055);
        c2f_in(1'b1, 2'd1, 32'h0800_0000, 32'h0000_00E0);
        step();
        c2f_in(1'b1, 2'd1, 32'h0800_0001, 32'h0000_00E1);
        step();
        c2f_in(1'b0, 2'd0, 32'h0, 32'h0);
        chk("half_f2c_valid",  {31'b0, F2C_ReqValidQ502H}, 32'd1);
        chk("half_f2c_data",   F2C_ReqDataQ502H, 32'h0000_00D0);
        chk("half_c2f_ready",  {31'b0, C2F_ReqReadyQ500H}, 32'd1);
        chk("half_ring_data",  RingOutputDataQ502H, 32'h0000_0055);
        #1;
        RstQnnnL = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        ring_in(1'b0, 2'd0, 32'h0, 32'h0);
        step();
        RstQnnnL = 1'b1;
        step();
        step();
        chk("postrst_ring_valid", {31'b0, RingOutputValidQ502H}, 32'd0);
        chk("postrst_f2c_valid",  {31'b0, F2C_ReqValidQ502H}, 32'd0);

        // C2F fills behind a busy ring; ready drops and a fifth push is refused.
        ring_in(1'b1, 2'd0, 32'h0501_0000, 32'h0000_0066);
        step();
        for (int i = 0; i < 4; i++) begin
            c2f_in(1'b1, 2'd1, 32'h0A00_0000 + i, 32'h0000_00C0 + i);
            step();
            chk($sformatf("c2f_fill%0d_ready", i), {31'b0, C2F_ReqReadyQ500H}, (i < 3) ? 32'd1 : 32'd0);
        end
        c2f_in(1'b1, 2'd1, 32'h0A00_0004, 32'h0000_00C4);
        step();
        ring_in(1'b0, 2'd0, 32'h0, 32'h0);
        c2f_in(1'b0, 2'd0, 32'h0, 32'h0);
        step();
        step();
        chk("drain_ready", {31'b0, C2F_ReqReadyQ500H}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("drain%0d_valid", k), {31'b0, RingOutputValidQ502H}, 32'd1);
            chk($sformatf("drain%0d_data", k),  RingOutputDataQ502H, 32'h0000_00C0 + k);
            chk($sformatf("drain%0d_addr", k),  RingOutputAddressQ502H, 32'h0A03_0000 + k);
            step();
        end
        chk("drain_refused", {31'b0, RingOutputValidQ502H}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
